// File: rtl/mem_pkg.sv
// Shared constants, response beat type and helpers for the memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  localparam int WORD_W     = 64;
  localparam int BYTE_OFF_W = 3;

  localparam logic [WORD_W-1:0] OOB_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;

  // One slot of the read-latency pipeline.
  typedef struct packed {
    logic              vld;
    logic [WORD_W-1:0] dat;
  } rd_beat_t;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth valid+data delay line carrying read responses to the output.
// Latency: DEPTH cycles from req_vld sample to rsp_vld.
// Backpressure: none; accepts a beat every cycle, clr empties all stages.
//
// Ports:
//   clk, clr          clock and synchronous clear (drops everything in flight)
//   req_vld, req_dat  beat entering stage 0
//   rsp_vld, rsp_dat  last stage; rsp_dat holds the last delivered beat
module mem_latency_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_vld,
  input  logic [WORD_W-1:0] req_dat,
  output logic              rsp_vld,
  output logic [WORD_W-1:0] rsp_dat
);

  rd_beat_t [DEPTH-1:0] stage_q;
  rd_beat_t [DEPTH-1:0] stage_nxt;

  always_comb begin
    stage_nxt = '0;
    stage_nxt[0].vld = req_vld;
    stage_nxt[0].dat = req_dat;
    for (int i = 1; i < DEPTH; i++) begin
      stage_nxt[i] = stage_q[i-1];
    end
  end

  // Inner stages shift freely; the output stage only loads on a valid beat
  // so its data field keeps the last delivered response between beats.
  always_ff @(posedge clk) begin
    if (clr) begin
      stage_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i != DEPTH - 1) || stage_nxt[i].vld) begin
          stage_q[i] <= stage_nxt[i];
        end else begin
          stage_q[i].vld <= 1'b0;
        end
      end
    end
  end

  assign rsp_vld = stage_q[DEPTH-1].vld;
  assign rsp_dat = stage_q[DEPTH-1].dat;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed 64-bit memory model answering single-beat reads and writes.
// Latency: reads respond READ_LATENCY cycles after acceptance; writes give no response.
// Backpressure: none; one request per cycle is always accepted (ignored while rst).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_req, mem_we          request strobe, 1 = write / 0 = read
//   mem_addr, mem_wdata      byte address, write data
//   mem_valid, mem_rdata     read response strobe and data
//   err_oob, err_misalign    sticky error flags
//   rd_count, wr_count       saturating accepted-request counters
module mem_responder
  import mem_pkg::*;
#(
  parameter int                DEPTH_WORDS  = 4096,
  parameter int                READ_LATENCY = 2,
  parameter logic [WORD_W-1:0] OOB_DATA     = OOB_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              mem_valid,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              err_oob,
  output logic              err_misalign,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic              acc;
  logic              acc_rd;
  logic              acc_wr;
  logic [IDX_W-1:0]  word_idx;
  logic              addr_oob;
  logic              addr_misalign;
  logic [WORD_W-1:0] rd_dat;

  assign acc    = mem_req & ~rst;
  assign acc_rd = acc & ~mem_we;
  assign acc_wr = acc & mem_we;

  assign word_idx = mem_addr[BYTE_OFF_W +: IDX_W];
  // Any set bit above the index field puts the address at or beyond
  // DEPTH_WORDS*8, which covers the full 64-bit compare.
  assign addr_oob      = |mem_addr[WORD_W-1:BYTE_OFF_W+IDX_W];
  assign addr_misalign = |mem_addr[BYTE_OFF_W-1:0];

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (acc_wr && !addr_oob) begin
      mem[word_idx] <= mem_wdata;
    end
  end

  // Read data is captured at acceptance; later writes cannot alter it.
  assign rd_dat = addr_oob ? OOB_DATA : mem[word_idx];

  mem_latency_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .clr     (rst),
    .req_vld (acc_rd),
    .req_dat (rd_dat),
    .rsp_vld (mem_valid),
    .rsp_dat (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob      <= 1'b0;
      err_misalign <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      if (acc && addr_oob)      err_oob      <= 1'b1;
      if (acc && addr_misalign) err_misalign <= 1'b1;
      if (acc_rd)               rd_count     <= sat_inc(rd_count);
      if (acc_wr)               wr_count     <= sat_inc(wr_count);
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 64-bit words stored; power of two, 16..65536.
REQ-002 Parameter READ_LATENCY, default 2, cycles from request sample to mem_valid; legal 1..8.
REQ-003 Parameter OOB_DATA, default 64'hDEAD_BEEF_DEAD_BEEF, read data returned for out-of-range addresses.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mem_req  input  1  request strobe, one request per high cycle.
REQ-008 mem_we  input  1  1 = write, 0 = read; qualified by mem_req.
REQ-009 mem_addr  input  64  byte address.
REQ-010 mem_wdata  input  64  write data; qualified by mem_req & mem_we.
REQ-011 mem_valid  output  1  single-cycle read-response strobe.
REQ-012 mem_rdata  output  64  read data; meaningful only when mem_valid=1.
REQ-013 err_oob  output  1  sticky: an out-of-range access occurred.
REQ-014 err_misalign  output  1  sticky: an access had mem_addr[2:0] != 0.
REQ-015 rd_count  output  32  accepted reads, saturating.
REQ-016 wr_count  output  32  accepted writes, saturating.

Function
REQ-017 Request accepted on every rising edge with mem_req=1; no backpressure; back-to-back requests every cycle supported.
REQ-018 Word index = mem_addr[3 +: log2(DEPTH_WORDS)]; mem_addr[2:0] ignored for addressing; nonzero sets err_misalign.
REQ-019 Out-of-range: mem_addr >= DEPTH_WORDS*8 (all 64 bits compared); write dropped, read returns OOB_DATA, err_oob set.
REQ-020 In-range write: mem_wdata stored at word index on the accepting edge; no response generated.
REQ-021 Read accepted at edge T: mem_valid=1 for exactly the cycle following edge T+READ_LATENCY-1 (latency 1 = valid the cycle after request), with mem_rdata = word contents at edge T.
REQ-022 Read data sampled at acceptance: a write accepted at edge T-1 is visible to a read at edge T; a write accepted after edge T does not affect that read's data.
REQ-023 Up to READ_LATENCY reads in flight; responses in request order, one per cycle, never merged or dropped.
REQ-024 mem_valid=0 in all cycles without a due response; mem_rdata holds the last delivered value between responses.
REQ-025 rd_count/wr_count increment by 1 per accepted read/write (including out-of-range); hold at 32'hFFFF_FFFF.
REQ-026 err_oob, err_misalign set on the accepting edge, cleared only by reset.

Reset
REQ-027 rst=1 at an edge: mem_valid=0, mem_rdata=0, err_oob=0, err_misalign=0, rd_count=0, wr_count=0, latency pipeline emptied.
REQ-028 Requests presented while rst=1 are ignored; reads in flight at reset are discarded and never produce mem_valid.
REQ-029 Storage array contents are not reset; contents are preserved across reset.

Structure
REQ-030 Shared package mem_pkg holds WORD_W=64, BYTE_OFF_W=3, and the OOB_DATA default constant.
REQ-031 One sub-module, mem_latency_pipe: valid+data shift register of depth READ_LATENCY with synchronous clear.
REQ-032 Storage is a single-port array inferred as one synchronous write port plus a read port feeding mem_latency_pipe.

Verification
REQ-033 Write addr 0x40 data 0x1111_2222_3333_4444, then read 0x40 next cycle -> mem_valid 2 cycles after read, rdata 0x1111_2222_3333_4444.
REQ-034 Reads to 0x0,0x8,0x10 on three consecutive cycles (preloaded 1,2,3) -> three consecutive mem_valid cycles with rdata 1,2,3.
REQ-035 Read addr 0x8000 with DEPTH_WORDS=4096 -> rdata 0xDEAD_BEEF_DEAD_BEEF, err_oob=1; write 0x8000 leaves memory unchanged.
REQ-036 Write 0x43 data 0xAA -> stored at word 8, err_misalign=1; read 0x40 returns 0xAA.
REQ-037 Issue read, assert rst one cycle later -> no mem_valid afterward; counters 0; earlier written data still readable.
REQ-038 READ_LATENCY=1, reads every cycle for 10 cycles -> mem_valid high 10 consecutive cycles, rd_count=10.
